// File: rtl/ssfpm_pkg.sv
// ssfpm_pkg: shared constants and segment-select function for the segmented multiplier
package ssfpm_pkg;
    localparam int MAX_W = 64;
    typedef struct packed {
        logic             sel;
        logic [MAX_W-1:0] seg;
    } seg_t;
    function automatic int sh_hi(input int n, input int m);
        return n - m;
    endfunction
    function automatic int res_w(input int n);
        return 2 * n;
    endfunction
    function automatic seg_t seg_select(input logic [MAX_W-1:0] x, input int n, input int m, input logic corr);
        seg_t r;
        logic [MAX_W-1:0] mask;
        mask = (64'd1 << m) - 64'd1;
        r.sel = (x >> m) != '0;
        r.seg = r.sel ? ((x >> (n - m)) & mask) : (x & mask);
        // round up on the first dropped bit, saturating instead of wrapping
        if (corr && r.sel && ((x >> (n - m - 1)) & 64'd1) != '0 && r.seg != mask)
            r.seg = r.seg + 64'd1;
        return r;
    endfunction
endpackage

// File: rtl/ssm_seg_sel.sv
// ssm_seg_sel: combinational segment select and rounding correction for one operand
module ssm_seg_sel
    import ssfpm_pkg::*;
#(
    parameter int N = 23,
    parameter int M = 14
) (
    input  logic [N-1:0] x,
    input  logic         corr_en,
    output logic [M-1:0] seg,
    output logic         sel
);
    seg_t r;
    logic unused_hi;
    assign r         = seg_select({{(MAX_W-N){1'b0}}, x}, N, M, corr_en);
    assign seg       = r.seg[M-1:0];
    assign sel       = r.sel;
    assign unused_hi = ^r.seg[MAX_W-1:M];
endmodule

// File: rtl/mmssm_pipe_param.sv
// mmssm_pipe_param: 3-stage elastic segmented approximate multiplier
module mmssm_pipe_param
    import ssfpm_pkg::*;
#(
    parameter int N     = 23,
    parameter int M     = 14,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          a,
    input  logic [N-1:0]          b,
    input  logic                  corr_en,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [res_w(N)-1:0]   ris,
    output logic [TAG_W-1:0]      out_tag
);
    localparam int SH = sh_hi(N, M);
    localparam int RW = res_w(N);
    localparam int SW = $clog2(2 * SH + 1);

    logic [M-1:0]     seg_a, seg_b, sa1, sb1;
    logic             sel_a, sel_b;
    logic [SW-1:0]    sh_sum, sh1, sh2;
    logic [2*M-1:0]   p2;
    logic [TAG_W-1:0] t1, t2;
    logic             v1, v2, ld1, ld2, ld3;

    ssm_seg_sel #(.N(N), .M(M)) u_sel_a (.x(a), .corr_en(corr_en), .seg(seg_a), .sel(sel_a));
    ssm_seg_sel #(.N(N), .M(M)) u_sel_b (.x(b), .corr_en(corr_en), .seg(seg_b), .sel(sel_b));

    assign sh_sum   = (sel_a ? SW'(SH) : '0) + (sel_b ? SW'(SH) : '0);
    // ready ripples back from out_ready so a full pipe still streams one per cycle
    assign ld3      = v2 && (!out_valid || out_ready);
    assign ld2      = v1 && (!v2 || ld3);
    assign in_ready = !v1 || ld2;
    assign ld1      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            sa1       <= '0;
            sb1       <= '0;
            sh1       <= '0;
            t1        <= '0;
            p2        <= '0;
            sh2       <= '0;
            t2        <= '0;
            ris       <= '0;
            out_tag   <= '0;
        end else begin
            v1        <= ld1 ? 1'b1 : (ld2 ? 1'b0 : v1);
            v2        <= ld2 ? 1'b1 : (ld3 ? 1'b0 : v2);
            out_valid <= ld3 ? 1'b1 : (out_ready ? 1'b0 : out_valid);
            if (ld1) begin
                sa1 <= seg_a;
                sb1 <= seg_b;
                sh1 <= sh_sum;
                t1  <= in_tag;
            end
            if (ld2) begin
                p2  <= (2*M)'(sa1) * (2*M)'(sb1);
                sh2 <= sh1;
                t2  <= t1;
            end
            if (ld3) begin
                ris     <= RW'(p2) << sh2;
                out_tag <= t2;
            end
        end
    end
endmodule

// File: tb/tb_mmssm_pipe_param.sv
// tb_mmssm_pipe_param: scoreboard bench for the segmented multiplier pipeline
module tb_mmssm_pipe_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [22:0] a = '0;
    logic [22:0] b = '0;
    logic        corr_en = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [45:0] ris;
    logic [3:0]  out_tag;

    typedef struct {
        logic [3:0]  tag;
        logic [45:0] ris;
    } exp_t;
    exp_t q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    logic rnd = 1'b0;

    mmssm_pipe_param #(.N(23), .M(14), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .corr_en(corr_en), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .ris(ris), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] tseg(input logic [22:0] x, input logic c);
        logic [13:0] s;
        if (x[22:14] != 0) begin
            s = x[22:9];
            if (c && x[8] && s != 14'h3fff) s = s + 14'd1;
        end else s = x[13:0];
        return s;
    endfunction

    function automatic logic [45:0] model(input logic [22:0] x, input logic [22:0] y, input logic c);
        logic [45:0] pa, pb;
        int sh;
        pa = 46'(tseg(x, c));
        pb = 46'(tseg(y, c));
        sh = (x[22:14] != 0 ? 9 : 0) + (y[22:14] != 0 ? 9 : 0);
        return (pa * pb) << sh;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                chk("ris", ris, q[0].ris);
                chk("tag", out_tag, q[0].tag);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd) out_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic send(input logic [22:0] x, input logic [22:0] y, input logic c,
                        input logic [3:0] t, input logic [45:0] e);
        int n = 0;
        a = x; b = y; corr_en = c; in_tag = t; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{t, e});
                break;
            end
            n++;
            if (n > 100) begin
                chk("accept_timeout", n, 0);
                break;
            end
            step();
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_latency(input string tag);
        int n = 1;
        forever begin
            @(negedge clk);
            if (out_valid || n > 20) break;
            @(posedge clk);
            n++;
        end
        chk(tag, n, 3);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        logic [22:0] x, y;
        logic        c;
        int          idx;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ris", ris, 0);
        chk("rst_out_tag", out_tag, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        send(23'd100, 23'd200, 1'b0, 4'd1, 46'd20000);
        check_latency("latency_basic");
        drain();
        send(23'h400000, 23'd3, 1'b0, 4'd2, 46'd12582912);
        send(23'h4001FF, 23'd1, 1'b1, 4'd3, 46'h400200);
        send(23'h4001FF, 23'd1, 1'b0, 4'd4, 46'h400000);
        send(23'h7FFFFF, 23'd1, 1'b1, 4'd5, 46'h7FFE00);
        send(23'd0, 23'h7FFFFF, 1'b1, 4'd6, 46'd0);
        send(23'h7FFFFF, 23'd0, 1'b1, 4'd7, 46'd0);
        drain();

        out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            a = 23'(1000 + idx * 37); b = 23'h400000 >> idx; corr_en = idx[0];
            in_tag = idx[3:0]; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{idx[3:0], model(a, b, corr_en)});
                idx++;
            end
            step();
        end
        chk("stall_accepts", idx, 3);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = idx; k < 6; k++) begin
            x = 23'(1000 + k * 37); y = 23'h400000 >> k;
            send(x, y, k[0], k[3:0], model(x, y, k[0]));
        end
        drain();

        send(23'h123456, 23'h00ABCD, 1'b1, 4'd8, model(23'h123456, 23'h00ABCD, 1'b1));
        send(23'h3FFFFF, 23'h7FF000, 1'b0, 4'd9, model(23'h3FFFFF, 23'h7FF000, 1'b0));
        step();
        chk("pre_rst_out_valid", out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_ris", ris, 0);
        chk("mid_rst_out_tag", out_tag, 0);
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        send(23'd100, 23'd200, 1'b0, 4'd10, 46'd20000);
        check_latency("latency_post_rst");
        repeat (6) step();
        chk("post_rst_empty", q.size(), 0);

        rnd = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
            case ($urandom_range(0, 3))
                0: begin x = 23'($urandom_range(0, 16383)); y = 23'($urandom_range(0, 16383)); end
                1: begin x = 23'($urandom); y = 23'($urandom); end
                2: begin x = ($urandom_range(0, 1) != 0) ? 23'h7FFFFF : 23'h4001FF; y = 23'($urandom_range(0, 2)); end
                default: begin x = 23'($urandom); y = 23'($urandom_range(0, 16383)); end
            endcase
            c = 1'($urandom_range(0, 1));
            send(x, y, c, i[3:0], model(x, y, c));
        end
        rnd = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
